// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready handshake between uart_rx and its consumer
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master(output rx_data, output rx_valid, input rx_ready);
  modport slave(input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 16x oversampling, one-entry valid/ready holding register; define UART_RX_PARITY_EN for 8E1 frames
module uart_rx #(
  parameter int CLOCK = 50,
  parameter int BAUD  = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun
);
  localparam int DIV = (CLOCK * 1000000) / (BAUD * 16);
  localparam int TW  = $clog2(DIV);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, rxs_q, rxs_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d, data_q, data_d;
  logic          commit_q, commit_d, ferr_q, ferr_d, ovr_q, ovr_d, valid_q, valid_d;
  logic          tick, mid, good, load;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
`endif

  // next-state logic: synchronizer, oversample timing, framing FSM and holding register
  always_comb begin
    tick     = tcnt_q == TW'(DIV - 1);
    mid      = tick && scnt_q == 4'd15;
    sync1_d  = rx;
    rxs_d    = sync1_q;
    tcnt_d   = tick ? '0 : tcnt_q + 1'b1;
    scnt_d   = tick ? scnt_q + 4'd1 : scnt_q;
    state_d  = state_q;
    bidx_d   = bidx_q;
    sh_d     = sh_q;
    commit_d = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
    good     = rxs_q && !perr_q;
`else
    good     = rxs_q;
`endif
    case (state_q)
      IDLE: if (!rxs_q) begin
        state_d = START;
        tcnt_d  = '0;
        scnt_d  = '0;
      end
      START: if (tick && scnt_q == 4'd7) begin
        state_d = rxs_q ? IDLE : DATA;
        scnt_d  = '0;
        bidx_d  = '0;
      end
      DATA: if (mid) begin
        sh_d   = {rxs_q, sh_q[7:1]};
        bidx_d = bidx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bidx_q == 3'd7) state_d = PARITY;
`else
        if (bidx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) begin
        perr_d  = ^{sh_q, rxs_q};
        state_d = STOP;
      end
`endif
      STOP: if (mid) begin
        state_d  = rxs_q ? IDLE : BREAK;
        commit_d = good;
        ferr_d   = !good;
      end
      BREAK: if (rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load    = commit_q && (!valid_q || bus.rx_ready);
    valid_d = load || (valid_q && !bus.rx_ready);
    data_d  = load ? sh_q : data_q;
    ovr_d   = commit_q && !load;
  end

  // state registers; reset idles the line high and empties the holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b1;
      rxs_q    <= 1'b1;
      tcnt_q   <= '0;
      scnt_q   <= '0;
      bidx_q   <= '0;
      sh_q     <= '0;
      data_q   <= '0;
      commit_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      rxs_q    <= rxs_d;
      tcnt_q   <= tcnt_d;
      scnt_q   <= scnt_d;
      bidx_q   <= bidx_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      commit_q <= commit_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      valid_q  <= valid_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame-level checks of uart_rx against a byte-queue reference model
module tb_uart_rx;
  localparam int CLK_MHZ = 50;
  localparam int BAUD    = 115200;
  localparam int DIV     = (CLK_MHZ * 1000000) / (BAUD * 16);
  localparam int BIT     = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int TICKS = 168;
`else
  localparam int TICKS = 152;
`endif

  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic frame_err, overrun;
  logic v_prev = 1'b0;
  logic [7:0] pat;
  logic [7:0] exp_q[$];
  int n_vec, n_err, n_ferr, n_ovr, e_ferr, e_ovr, cyc, v_cyc, t_start;

  uart_rx_if bus();
  uart_rx #(.CLOCK(CLK_MHZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .bus(bus), .frame_err(frame_err), .overrun(overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wt(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 good frame, 1 stop bit low, 2 wrong parity (8E1 only)
  task automatic send(logic [7:0] b, int kind);
    t_start = cyc;
    rx = 1'b0; wt(BIT);
    for (int i = 0; i < 8; i++) begin rx = b[i]; wt(BIT); end
`ifdef UART_RX_PARITY_EN
    rx = ^b ^ (kind == 2); wt(BIT);
`endif
    rx = (kind != 1); wt(BIT);
  endtask

  task automatic checkpoint(string tag);
    chk({tag, "/queue"}, 32'(exp_q.size()), 0);
    chk({tag, "/frame_err"}, 32'(n_ferr), 32'(e_ferr));
    chk({tag, "/overrun"}, 32'(n_ovr), 32'(e_ovr));
  endtask

  // consumer-side monitor: every accepted byte must be the oldest expected byte
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid && bus.rx_ready) begin
      chk("byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
    end
    if (bus.rx_valid === 1'b1 && v_prev !== 1'b1) v_cyc = cyc;
    v_prev = bus.rx_valid;
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d exceeded budget of 150000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_ready = 1'b1;
    wt(3);
    chk("reset/rx_valid", 32'(bus.rx_valid), 0);
    chk("reset/rx_data", 32'(bus.rx_data), 0);
    chk("reset/frame_err", 32'(frame_err), 0);
    chk("reset/overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    wt(2);

    exp_q.push_back(8'hA5);
    send(8'hA5, 0);
    wt(8);
    chk("latency", 32'(v_cyc - t_start), 32'(TICKS * DIV + 4));
    checkpoint("a5");

    rx = 1'b0; wt(100); rx = 1'b1; wt(BIT);
    checkpoint("glitch");

    e_ferr++;
    send(8'h3C, 1);
    wt(2000);
    rx = 1'b1; wt(BIT);
    exp_q.push_back(8'h11);
    send(8'h11, 0);
    wt(8);
    checkpoint("break");

    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h55);
    e_ovr++;
    send(8'h55, 0);
    send(8'hAA, 0);
    wt(8);
    chk("hold/rx_data", 32'(bus.rx_data), 32'h55);
    chk("hold/rx_valid", 32'(bus.rx_valid), 1);
    bus.rx_ready = 1'b1;
    wt(1);
    chk("release/rx_valid", 32'(bus.rx_valid), 0);
    checkpoint("overrun");

    foreach (pat[i]) begin end
    for (int i = 0; i < 3; i++) begin
      pat = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h80;
      exp_q.push_back(pat);
      send(pat, 0);
    end
    wt(8);
    checkpoint("b2b");

    bus.rx_ready = 1'b0;
    send(8'h96, 0);
    wt(8);
    chk("pre_reset/rx_valid", 32'(bus.rx_valid), 1);
    chk("pre_reset/rx_data", 32'(bus.rx_data), 32'h96);
    pat = 8'h5A;
    rx = 1'b0; wt(BIT);
    for (int i = 0; i < 4; i++) begin rx = pat[i]; wt(BIT); end
    rx = pat[4]; wt(BIT / 2);
    rst_n = 1'b0; wt(2);
    rst_n = 1'b1; rx = 1'b1;
    chk("post_reset/rx_valid", 32'(bus.rx_valid), 0);
    chk("post_reset/rx_data", 32'(bus.rx_data), 0);
    chk("post_reset/frame_err", 32'(frame_err), 0);
    chk("post_reset/overrun", 32'(overrun), 0);
    wt(2 * BIT);
    chk("idle_after_reset/rx_valid", 32'(bus.rx_valid), 0);
    bus.rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send(8'hC3, 0);
    wt(8);
    checkpoint("reset");

`ifdef UART_RX_PARITY_EN
    e_ferr++;
    send(8'h07, 2);
    rx = 1'b1; wt(8);
    checkpoint("parity");
`endif

    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      int kind, gap;
      b = 8'($urandom);
      kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
`ifdef UART_RX_PARITY_EN
      if (kind == 0 && $urandom_range(0, 3) == 0) kind = 2;
`endif
      if (kind == 0) exp_q.push_back(b); else e_ferr++;
      send(b, kind);
      rx = 1'b1;
      gap = $urandom_range(0, 200) + ((kind == 1) ? 8 : 0);
      if (gap > 0) wt(gap);
    end
    wt(BIT);
    checkpoint("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 frames, LSB first, 16x oversampling.
- Sits between the board RX pin and the core's byte consumer (debug/boot loader path).
- Delivers each byte through a one-entry holding register with a valid/ready handshake.
- Timing is derived from the same Clock/Baud parameters as the core top level.

Parameters:
CLOCK, 50, system clock frequency in MHz
BAUD, 115200, line rate in bit/s; oversample divider DIV = (CLOCK*1000000)/(BAUD*16), integer truncation (27 at defaults); DIV >= 2 required

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low; all state is sampled on posedge clk
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready at posedge clk
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while holding register full and not being consumed

Behaviour:
- Reset (rst_n=0 at posedge clk): rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE, tick/bit counters=0, both synchronizer flops=1.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- Tick generator: counts 0..DIV-1 and emits a one-cycle tick at DIV-1. It is cleared on the IDLE->START transition so that sampling aligns to the detected edge.
- IDLE: on rxs=0, go to START; clear the tick counter and sample counter.
- START: on the 8th tick (mid start bit), if rxs=1, treat it as a glitch and return to IDLE with no outputs. Otherwise go to DATA with bit index 0 and sample counter 0.
- DATA: every 16th tick, shift rxs into a shift register, LSB first. After bit 7 is sampled, go to STOP.
- STOP: on the 16th tick (mid stop bit), act on the sampled value:
  - rxs=1: the frame is good; commit and go to IDLE.
  - rxs=0: pulse frame_err, discard the byte, and go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Commit cycle (cycle after mid-stop sample):
  - rx_valid=0, or rx_valid&&rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=0: keep the old byte, drop the new one, pulse overrun.
- Handshake:
  - rx_valid falls the cycle after rx_valid&&rx_ready, unless a commit happens in that same cycle.
  - rx_ready while rx_valid=0 is ignored.
  - rx_data is unchanged except on commit.
- Latency: start-edge detection to rx_valid = 152 ticks (152*DIV cycles, 4104 at defaults) plus 3-4 clk cycles of synchronizer/FSM delay.
- Reset mid-frame: the frame is abandoned, the FSM returns to IDLE, and any held byte is lost. After reset the line is re-acquired from the next falling edge.
- The next start bit may begin immediately after mid-stop, which gives half a bit of resync margin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples at the 16th tick.
  - Parity mismatch (XOR of data bits and parity bit = 1): the byte is discarded, frame_err pulses at mid-stop, and the FSM goes to IDLE (BREAK if stop=0).
  - Latency becomes 168 ticks.
- Undefined: 8N1 only; the PARITY state and its logic are absent.

Test Plan:
- Defaults, rx_ready=1, send 0xA5 at 115200 (432 cycles/bit) -> one rx_valid pulse with rx_data=0xA5 about 4107 cycles after the start edge; frame_err=0, overrun=0.
- Low glitch of 100 cycles on idle rx -> FSM returns to IDLE; no rx_valid and no frame_err.
- Send 0x3C with stop bit forced 0, then rx held low 2000 cycles, then high, then send 0x11 -> one frame_err pulse and no byte for 0x3C, no extra frames while low, then 0x11 received.
- rx_ready=0, send 0x55 then 0xAA back-to-back -> rx_data stays 0x55 and rx_valid stays 1; overrun pulses once at the 0xAA commit. Raising rx_ready clears rx_valid the next cycle.
- rx_ready=1, send 0x00, 0xFF, 0x80 back-to-back with no idle gap -> three valid bytes in order, no errors.
- Assert rst_n=0 for 2 cycles during DATA bit 4 of 0x5A, then send 0xC3 -> no byte for 0x5A, all outputs 0 after reset, 0xC3 received. With UART_RX_PARITY_EN, also send 0x07 with wrong parity -> frame_err, no rx_valid.
